// File: rtl/guess_sequencer.sv
// guess_sequencer: player-side driver for the Znarly/Zood game controller.
// Buffers host guesses in a FIFO, starts a game, issues each guess with a
// one-cycle GradeIt strobe and captures the controller feedback.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start_req, flush        host game request / synchronous abort
//   push, guess_in          guess enqueue
//   full, empty, overflow   FIFO status (overflow is sticky)
//   NumGames, LoadDone      controller credit / master pattern loaded
//   loadZnarlyZood          controller feedback strobe
//   displayMasterPattern    game-finished indication
//   Znarly, Zood, GameWon   controller feedback
//   StartGame, GradeIt      registered one-cycle strobes to controller
//   Guess                   registered guess to controller
//   res_valid, res_*        captured feedback
//   round, game_over        per-game progress
module guess_sequencer #(
    parameter int DEPTH = 4,
    parameter int GW    = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_req,
    input  logic          flush,
    input  logic          push,
    input  logic [GW-1:0] guess_in,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic [3:0]    NumGames,
    input  logic          LoadDone,
    input  logic          loadZnarlyZood,
    input  logic          displayMasterPattern,
    input  logic [3:0]    Znarly,
    input  logic [3:0]    Zood,
    input  logic          GameWon,
    output logic          StartGame,
    output logic          GradeIt,
    output logic [GW-1:0] Guess,
    output logic          res_valid,
    output logic [3:0]    res_znarly,
    output logic [3:0]    res_zood,
    output logic          res_won,
    output logic [3:0]    round,
    output logic          game_over
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOAD,
        ARMED,
        WAIT_FB,
        DONE
    } state_t;

    state_t state, next_state;

    logic [GW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic do_start, do_grade, do_cap;
    logic pop, push_ok, push_drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees a slot, so a push to a full FIFO is kept.
    assign pop       = do_grade;
    assign push_ok   = push && !flush && (!full || pop);
    assign push_drop = push && !flush && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_start   = 1'b0;
        do_grade   = 1'b0;
        do_cap     = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_req && NumGames != 4'd0) begin
                        next_state = START;
                        do_start   = 1'b1;
                    end
                end
                START: next_state = WAIT_LOAD;
                WAIT_LOAD: begin
                    if (LoadDone) next_state = ARMED;
                end
                ARMED: begin
                    if (!empty) begin
                        next_state = WAIT_FB;
                        do_grade   = 1'b1;
                    end
                end
                WAIT_FB: begin
                    if (loadZnarlyZood) begin
                        do_cap     = 1'b1;
                        next_state = displayMasterPattern ? DONE : ARMED;
                    end
                end
                DONE: begin
                    // Wait for the request to drop so one held level
                    // cannot start a second game.
                    if (!start_req) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= guess_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);
            if (push_drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            StartGame  <= 1'b0;
            GradeIt    <= 1'b0;
            Guess      <= '0;
            res_valid  <= 1'b0;
            res_znarly <= 4'd0;
            res_zood   <= 4'd0;
            res_won    <= 1'b0;
            round      <= 4'd0;
            game_over  <= 1'b0;
        end else begin
            StartGame <= do_start;
            GradeIt   <= do_grade;
            res_valid <= do_cap;
            if (do_grade) Guess <= mem[rd_ptr];
            if (do_start) begin
                round     <= 4'd0;
                game_over <= 1'b0;
            end
            if (do_cap) begin
                res_znarly <= Znarly;
                res_zood   <= Zood;
                res_won    <= GameWon;
                if (round != 4'hF) round <= round + 4'd1;
                if (displayMasterPattern) game_over <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_guess_sequencer.sv
// tb_guess_sequencer: directed self-checking bench for guess_sequencer.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_guess_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_req = 1'b0;
    logic        flush = 1'b0;
    logic        push = 1'b0;
    logic [11:0] guess_in = '0;
    logic        full, empty, overflow;
    logic [3:0]  NumGames = 4'd0;
    logic        LoadDone = 1'b0;
    logic        loadZnarlyZood = 1'b0;
    logic        displayMasterPattern = 1'b0;
    logic [3:0]  Znarly = 4'd0;
    logic [3:0]  Zood = 4'd0;
    logic        GameWon = 1'b0;
    logic        StartGame, GradeIt;
    logic [11:0] Guess;
    logic        res_valid;
    logic [3:0]  res_znarly, res_zood;
    logic        res_won;
    logic [3:0]  round;
    logic        game_over;

    int checks = 0;
    int passes = 0;

    guess_sequencer #(.DEPTH(4), .GW(12)) dut (
        .clock(clock), .reset(reset),
        .start_req(start_req), .flush(flush),
        .push(push), .guess_in(guess_in),
        .full(full), .empty(empty), .overflow(overflow),
        .NumGames(NumGames), .LoadDone(LoadDone),
        .loadZnarlyZood(loadZnarlyZood),
        .displayMasterPattern(displayMasterPattern),
        .Znarly(Znarly), .Zood(Zood), .GameWon(GameWon),
        .StartGame(StartGame), .GradeIt(GradeIt), .Guess(Guess),
        .res_valid(res_valid), .res_znarly(res_znarly),
        .res_zood(res_zood), .res_won(res_won),
        .round(round), .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_one(input logic [11:0] g);
        push = 1'b1;
        guess_in = g;
        tick();
        push = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_start", 32'(StartGame), 0);
        chk("rst_grade", 32'(GradeIt), 0);
        chk("rst_guess", 32'(Guess), 0);
        chk("rst_round", 32'(round), 0);
        chk("rst_gover", 32'(game_over), 0);
        chk("rst_rvalid", 32'(res_valid), 0);
        tick();
        reset = 1'b0;
        tick();

        // start_req with no credited games
        start_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nogames_start", 32'(StartGame), 0);
        end
        start_req = 1'b0;
        tick();

        // game 1: three preloaded guesses
        push_one(12'h123);
        push_one(12'h456);
        push_one(12'h701);
        chk("pre_empty", 32'(empty), 0);
        chk("pre_full", 32'(full), 0);
        NumGames = 4'd2;
        start_req = 1'b1;
        tick();
        chk("g1_start", 32'(StartGame), 1);
        start_req = 1'b0;
        tick();
        chk("g1_start_off", 32'(StartGame), 0);
        tick();
        chk("g1_noload_grade", 32'(GradeIt), 0);
        LoadDone = 1'b1;
        tick();
        LoadDone = 1'b0;
        chk("g1_armed_grade", 32'(GradeIt), 0);
        tick();
        chk("g1_grade1", 32'(GradeIt), 1);
        chk("g1_guess1", 32'(Guess), 32'h123);
        tick();
        chk("g1_grade1_off", 32'(GradeIt), 0);
        chk("g1_guess1_hold", 32'(Guess), 32'h123);
        loadZnarlyZood = 1'b1; Znarly = 4'd2; Zood = 4'd1;
        tick();
        loadZnarlyZood = 1'b0;
        chk("g1_rv1", 32'(res_valid), 1);
        chk("g1_rz1", 32'(res_znarly), 2);
        chk("g1_rd1", 32'(res_zood), 1);
        chk("g1_round1", 32'(round), 1);
        tick();
        chk("g1_rv1_off", 32'(res_valid), 0);
        chk("g1_grade2", 32'(GradeIt), 1);
        chk("g1_guess2", 32'(Guess), 32'h456);
        loadZnarlyZood = 1'b1; Znarly = 4'd1; Zood = 4'd3;
        tick();
        loadZnarlyZood = 1'b0;
        chk("g1_rv2", 32'(res_valid), 1);
        chk("g1_rd2", 32'(res_zood), 3);
        chk("g1_round2", 32'(round), 2);
        tick();
        chk("g1_grade3", 32'(GradeIt), 1);
        chk("g1_guess3", 32'(Guess), 32'h701);
        chk("g1_empty", 32'(empty), 1);
        loadZnarlyZood = 1'b1; Znarly = 4'd4; Zood = 4'd0;
        GameWon = 1'b1; displayMasterPattern = 1'b1;
        tick();
        loadZnarlyZood = 1'b0; GameWon = 1'b0; displayMasterPattern = 1'b0;
        chk("g1_round3", 32'(round), 3);
        chk("g1_gover", 32'(game_over), 1);
        chk("g1_won", 32'(res_won), 1);
        tick();
        tick();

        // game 2: win on first grade, start_req held through DONE
        push_one(12'hAAA);
        push_one(12'hBBB);
        push_one(12'hCCC);
        start_req = 1'b1;
        tick();
        chk("g2_start", 32'(StartGame), 1);
        chk("g2_round_clr", 32'(round), 0);
        chk("g2_gover_clr", 32'(game_over), 0);
        tick();
        LoadDone = 1'b1;
        tick();
        LoadDone = 1'b0;
        tick();
        chk("g2_grade", 32'(GradeIt), 1);
        chk("g2_guess", 32'(Guess), 32'hAAA);
        loadZnarlyZood = 1'b1; Znarly = 4'd4; Zood = 4'd0;
        GameWon = 1'b1; displayMasterPattern = 1'b1;
        tick();
        loadZnarlyZood = 1'b0; GameWon = 1'b0; displayMasterPattern = 1'b0;
        chk("g2_rv", 32'(res_valid), 1);
        chk("g2_rz", 32'(res_znarly), 4);
        chk("g2_rd", 32'(res_zood), 0);
        chk("g2_won", 32'(res_won), 1);
        chk("g2_gover", 32'(game_over), 1);
        chk("g2_round", 32'(round), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("g2_held_start", 32'(StartGame), 0);
            chk("g2_held_grade", 32'(GradeIt), 0);
        end
        chk("g2_left", 32'(empty), 0);
        start_req = 1'b0;
        tick();
        tick();
        chk("g2_idle_start", 32'(StartGame), 0);
        loadZnarlyZood = 1'b1; Znarly = 4'd7;
        tick();
        loadZnarlyZood = 1'b0;
        chk("idle_lzz_rv", 32'(res_valid), 0);
        chk("idle_lzz_rz", 32'(res_znarly), 4);

        // flush, then overflow
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty", 32'(empty), 1);
        push_one(12'h001);
        push_one(12'h002);
        push_one(12'h003);
        chk("ov_notfull", 32'(full), 0);
        push_one(12'h004);
        chk("ov_full", 32'(full), 1);
        chk("ov_noovf", 32'(overflow), 0);
        push_one(12'h005);
        chk("ov_ovf", 32'(overflow), 1);
        chk("ov_full2", 32'(full), 1);

        // game 3: push+pop while full, then flush in WAIT_FB
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        chk("g3_start", 32'(StartGame), 1);
        chk("g3_gover_clr", 32'(game_over), 0);
        tick();
        LoadDone = 1'b1;
        tick();
        LoadDone = 1'b0;
        push = 1'b1; guess_in = 12'h006;
        tick();
        push = 1'b0;
        chk("pp_grade", 32'(GradeIt), 1);
        chk("pp_guess", 32'(Guess), 32'h001);
        chk("pp_full", 32'(full), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty2", 32'(empty), 1);
        chk("fl_ovf", 32'(overflow), 0);
        chk("fl_grade", 32'(GradeIt), 0);
        loadZnarlyZood = 1'b1; Znarly = 4'd3;
        tick();
        loadZnarlyZood = 1'b0;
        chk("fl_lzz_rv", 32'(res_valid), 0);
        chk("fl_rz_keep", 32'(res_znarly), 4);
        chk("fl_round", 32'(round), 0);

        // reset while ARMED with non-empty FIFO
        push_one(12'h0F0);
        push_one(12'h00F);
        push_one(12'h111);
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        LoadDone = 1'b1;
        tick();
        LoadDone = 1'b0;
        tick();
        chk("pre_rst_grade", 32'(GradeIt), 1);
        chk("pre_rst_guess", 32'(Guess), 32'h0F0);
        loadZnarlyZood = 1'b1; Znarly = 4'd2;
        tick();
        loadZnarlyZood = 1'b0;
        chk("pre_rst_round", 32'(round), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_guess", 32'(Guess), 0);
        chk("mid_rst_round", 32'(round), 0);
        chk("mid_rst_rz", 32'(res_znarly), 0);
        chk("mid_rst_won", 32'(res_won), 0);
        chk("mid_rst_grade", 32'(GradeIt), 0);
        tick();
        chk("rst_hold_grade", 32'(GradeIt), 0);
        chk("rst_hold_start", 32'(StartGame), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_grade", 32'(GradeIt), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/guess_sequencer.md
# guess_sequencer

Player-side driver for the Znarly/Zood game controller. It buffers host-supplied 12-bit guesses in a small FIFO, requests a game start, and issues each guess with a one-cycle GradeIt strobe. It then waits for the controller's loadZnarlyZood strobe and captures the Znarly/Zood feedback into result registers. It sits opposite the game controller and drives that controller's StartGame, Guess and GradeIt inputs, so a bench or scripted demo can play a full game without switches.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- GW, 12, guess width: four 3-bit shape fields.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start_req  in  1  host request to begin a game; level, sampled in IDLE.
- flush  in  1  synchronous abort: empties the FIFO and returns to IDLE.
- push  in  1  enqueue guess_in.
- guess_in  in  GW  guess to enqueue.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- overflow  out  1  sticky: a push was dropped while full; cleared by flush or reset.
- NumGames  in  4  credited games from the controller.
- LoadDone  in  1  master pattern loaded.
- loadZnarlyZood  in  1  feedback strobe from the controller.
- displayMasterPattern  in  1  game-finished indication.
- Znarly, Zood  in  4 each  controller feedback.
- GameWon  in  1  controller win flag.
- StartGame  out  1  one-cycle start pulse.
- GradeIt  out  1  one-cycle grade strobe.
- Guess  out  GW  registered guess, held stable from the GradeIt cycle until feedback is captured.
- res_valid  out  1  one-cycle pulse when a result is captured.
- res_znarly, res_zood  out  4 each  captured feedback.
- res_won  out  1  captured GameWon.
- round  out  4  guesses graded this game; saturates at 15.
- game_over  out  1  sticky; set on the finishing feedback, cleared on the next StartGame.

## Operation
- States: IDLE, START, WAIT_LOAD, ARMED, WAIT_FB, DONE.
- IDLE
  - start_req=1 and NumGames!=0: go to START.
  - start_req=1 and NumGames==0: stay in IDLE.
- START: StartGame=1 for exactly this cycle; clear round and game_over; go to WAIT_LOAD.
- WAIT_LOAD: stay until LoadDone=1, then go to ARMED.
- ARMED
  - FIFO non-empty: GradeIt=1, Guess<=head, pop, go to WAIT_FB.
  - FIFO empty: wait.
- WAIT_FB: on loadZnarlyZood=1, capture Znarly, Zood and GameWon and increment round (saturating).
  - displayMasterPattern=1 in the same cycle: set game_over, go to DONE.
  - Otherwise: go to ARMED.
- DONE: go to IDLE when start_req=0, so one held request cannot start two games.
- FIFO behaviour:
  - Circular buffer; count is width clog2(DEPTH)+1.
  - Push while full is dropped and sets overflow, except when a pop occurs in the same cycle; then the push is accepted and count is unchanged.
  - Push while empty and popped in the same cycle is impossible, because the pop requires non-empty.
  - Pointers wrap modulo DEPTH.
- Pushes are accepted in every state, so guesses may be pre-loaded in IDLE.
- flush has priority over all other transitions. It clears the FIFO and overflow, drops StartGame and GradeIt, and goes to IDLE. It leaves the result registers, round and game_over unchanged.
- loadZnarlyZood outside WAIT_FB is ignored.

## Timing
- Reset values: state IDLE; StartGame, GradeIt, res_valid, overflow, game_over all 0; round=0; Guess=0; res_* = 0; FIFO empty (empty=1, full=0).
- StartGame and GradeIt are registered outputs. Each is high for exactly one cycle, the cycle after the state decision.
- Guess changes only together with GradeIt.
- res_valid and res_* update in the cycle after loadZnarlyZood is sampled, giving a capture latency of 1 cycle.
- Minimum guess-to-guess spacing: GradeIt, then at least 1 cycle in WAIT_FB, then ARMED. Back-to-back guesses are therefore at least 3 cycles apart.
- full and empty reflect the registered count; there is no combinational path from push.
- Reset mid-game returns to IDLE immediately (asynchronous); no StartGame or GradeIt pulse is emitted.

## Test plan
- Pre-load 3 guesses in IDLE with NumGames=2, raise start_req -> one StartGame pulse. After LoadDone, three GradeIt pulses appear with Guess equal to each entry in order. round ends at 3.
- Feedback Znarly=4, Zood=0, GameWon=1 with displayMasterPattern=1 on the first grade -> res_valid pulse; res_znarly=4, res_won=1, game_over=1; state DONE. The 2 remaining entries are not issued until the next game.
- Push 5 guesses with DEPTH=4 -> full=1 after 4; 5th dropped, overflow=1. Push and pop in the same cycle while full -> accepted, full stays 1.
- start_req=1 with NumGames=0 -> no StartGame; IDLE held. Holding start_req through DONE -> no second StartGame until start_req drops.
- flush asserted in WAIT_FB -> IDLE next cycle; empty=1; a later loadZnarlyZood produces no res_valid.
- Assert reset while ARMED with a non-empty FIFO -> all outputs at reset values immediately; empty=1.
